// File: rtl/mem_arb2.sv
// mem_arb2: two-requester arbiter in front of a single-ported memory.
// Requester 0 (instruction side) is served first and its read data is parked
// in buf0. Requester 1 (data side) may then issue a request derived from that
// data in the following cycle, and both requesters complete together.
module mem_arb2 #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             mem0_val,
    input  logic             mem0_type,
    input  logic [31:0]      mem0_addr,
    input  logic [31:0]      mem0_wdata,
    output logic             mem0_wait,
    output logic [31:0]      mem0_rdata,

    input  logic             mem1_val,
    input  logic             mem1_type,
    input  logic [31:0]      mem1_addr,
    input  logic [31:0]      mem1_wdata,
    output logic             mem1_wait,
    output logic [31:0]      mem1_rdata,

    output logic             mem_val,
    output logic             mem_type,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_wait,
    input  logic [31:0]      mem_rdata,

    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [31:0]      r_buf0;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    state_t           w_next;
    logic             w_sel1;
    logic             w_load_buf;
    logic             w_inc0;
    logic             w_inc1;

    // Grant, handshake and next-state decode; the grant never looks at
    // mem_rdata, so mem_rdata only reaches the two rdata outputs and buf0.
    always_comb begin
        w_next     = r_state;
        w_sel1     = 1'b0;
        w_load_buf = 1'b0;
        w_inc0     = 1'b0;
        w_inc1     = 1'b0;
        mem_val    = 1'b0;
        mem0_wait  = 1'b1;
        mem1_wait  = 1'b1;
        mem0_rdata = 32'd0;
        mem1_rdata = 32'd0;

        // While rst is high every output stays in its idle value even though
        // the requesters may still present a valid request.
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (mem0_val) begin
                        // Requester 0 wins without looking at requester 1; its
                        // result is parked and both are held off this cycle.
                        mem_val = 1'b1;
                        if (!mem_wait) begin
                            w_load_buf = 1'b1;
                            w_next     = ST_HOLD;
                        end
                    end else if (mem1_val) begin
                        mem_val    = 1'b1;
                        w_sel1     = 1'b1;
                        mem1_wait  = mem_wait;
                        mem1_rdata = mem_rdata;
                        w_inc1     = ~mem_wait;
                    end
                end
                ST_HOLD: begin
                    mem0_rdata = r_buf0;
                    if (mem1_val) begin
                        // Requester 0 completes alongside requester 1.
                        mem_val    = 1'b1;
                        w_sel1     = 1'b1;
                        mem0_wait  = mem_wait;
                        mem1_wait  = mem_wait;
                        mem1_rdata = mem_rdata;
                        if (!mem_wait) begin
                            w_inc0 = 1'b1;
                            w_inc1 = 1'b1;
                            w_next = ST_IDLE;
                        end
                    end else begin
                        mem0_wait = 1'b0;
                        w_inc0    = 1'b1;
                        w_next    = ST_IDLE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Memory request mux; fields read as zero whenever no request is issued.
    always_comb begin
        mem_type  = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (mem_val) begin
            mem_type  = w_sel1 ? mem1_type  : mem0_type;
            mem_addr  = w_sel1 ? mem1_addr  : mem0_addr;
            mem_wdata = w_sel1 ? mem1_wdata : mem0_wdata;
        end
    end

    // State, parked read data and wrapping completion counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_buf0  <= 32'd0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_buf) r_buf0 <= mem_rdata;
            if (w_inc0)     r_cnt0 <= r_cnt0 + 1'b1;
            if (w_inc1)     r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;

endmodule

// File: tb/tb_mem_arb2.sv
// Testbench for mem_arb2: table of per-cycle vectors plus hand-written
// sequences for memory stalls, reset in HOLD and counter wrap.
module tb_mem_arb2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_val = 1'b0, m0_type = 1'b0;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
    logic        m1_val = 1'b0, m1_type = 1'b0;
    logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
    logic        mw = 1'b0;

    logic        m0_wait, m1_wait, mem_val, mem_type;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] cnt0, cnt1;

    logic        d4_m0_wait, d4_m1_wait, d4_mem_val, d4_mem_type;
    logic [31:0] d4_m0_rdata, d4_m1_rdata, d4_mem_addr, d4_mem_wdata;
    logic [3:0]  d4_cnt0, d4_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on a completed write.
    logic [31:0] tmem [0:16383];
    assign mem_rdata = tmem[mem_addr[15:2]];
    always @(posedge clk) begin
        if (rst) begin
            tmem[32'h200  >> 2] <= 32'h0050_0093;
            tmem[32'h204  >> 2] <= 32'h00A0_0113;
            tmem[32'h1000 >> 2] <= 32'hCAFE_0001;
            tmem[32'h2000 >> 2] <= 32'h0000_0000;
        end else if (mem_val && !mw && mem_type) begin
            tmem[mem_addr[15:2]] <= mem_wdata;
        end
    end

    mem_arb2 #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .mem0_val(m0_val), .mem0_type(m0_type), .mem0_addr(m0_addr), .mem0_wdata(m0_wdata),
        .mem0_wait(m0_wait), .mem0_rdata(m0_rdata),
        .mem1_val(m1_val), .mem1_type(m1_type), .mem1_addr(m1_addr), .mem1_wdata(m1_wdata),
        .mem1_wait(m1_wait), .mem1_rdata(m1_rdata),
        .mem_val(mem_val), .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wait(mw), .mem_rdata(mem_rdata),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    // Narrow-counter copy fed the same stimulus; only its counters are checked.
    mem_arb2 #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .mem0_val(m0_val), .mem0_type(m0_type), .mem0_addr(m0_addr), .mem0_wdata(m0_wdata),
        .mem0_wait(d4_m0_wait), .mem0_rdata(d4_m0_rdata),
        .mem1_val(m1_val), .mem1_type(m1_type), .mem1_addr(m1_addr), .mem1_wdata(m1_wdata),
        .mem1_wait(d4_m1_wait), .mem1_rdata(d4_m1_rdata),
        .mem_val(d4_mem_val), .mem_type(d4_mem_type), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata),
        .mem_wait(mw), .mem_rdata(mem_rdata),
        .cnt0(d4_cnt0), .cnt1(d4_cnt1)
    );

    typedef struct {
        logic        v0, t0;
        logic [31:0] a0, d0;
        logic        v1, t1;
        logic [31:0] a1, d1;
        logic        e_val, e_type;
        logic [31:0] e_addr;
        logic        e_w0, e_w1;
        logic [31:0] e_rd0, e_rd1;
        logic [31:0] e_c0, e_c1;
    } vec_t;

    vec_t tbl [7];

    function automatic vec_t mk(
        input logic v0, input logic t0, input logic [31:0] a0, input logic [31:0] d0,
        input logic v1, input logic t1, input logic [31:0] a1, input logic [31:0] d1,
        input logic e_val, input logic e_type, input logic [31:0] e_addr,
        input logic e_w0, input logic e_w1, input logic [31:0] e_rd0, input logic [31:0] e_rd1,
        input logic [31:0] e_c0, input logic [31:0] e_c1);
        vec_t v;
        v.v0 = v0; v.t0 = t0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.t1 = t1; v.a1 = a1; v.d1 = d1;
        v.e_val = e_val; v.e_type = e_type; v.e_addr = e_addr;
        v.e_w0 = e_w0; v.e_w1 = e_w1; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        v.e_c0 = e_c0; v.e_c1 = e_c1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        m0_val = 1'b0; m0_type = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_val = 1'b0; m1_type = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        mw = 1'b0;
    endtask

    logic [5:0] wpat;

    initial begin
        //           v0 t0 a0       d0   v1 t1 a1        d1            val typ addr       w0 w1 rd0           rd1           c0 c1
        tbl[0] = mk(0, 0, 32'h0,   0,   0, 0, 32'h0,    0,            0,  0,  32'h0,     1, 1, 32'h0,        32'h0,        0, 0);
        tbl[1] = mk(1, 0, 32'h200, 0,   0, 0, 32'h0,    0,            1,  0,  32'h200,   1, 1, 32'h0,        32'h0,        0, 0);
        tbl[2] = mk(1, 0, 32'h200, 0,   0, 0, 32'h0,    0,            0,  0,  32'h0,     0, 1, 32'h00500093, 32'h0,        1, 0);
        tbl[3] = mk(1, 0, 32'h204, 0,   1, 0, 32'h1000, 0,            1,  0,  32'h204,   1, 1, 32'h0,        32'h0,        1, 0);
        tbl[4] = mk(1, 0, 32'h204, 0,   1, 0, 32'h1000, 0,            1,  0,  32'h1000,  0, 0, 32'h00A00113, 32'hCAFE0001, 2, 1);
        tbl[5] = mk(0, 0, 32'h0,   0,   1, 1, 32'h2000, 32'hDEADBEEF, 1,  1,  32'h2000,  1, 0, 32'h0,        32'h0,        2, 2);
        tbl[6] = mk(0, 0, 32'h0,   0,   1, 0, 32'h2000, 0,            1,  0,  32'h2000,  1, 0, 32'h0,        32'hDEADBEEF, 2, 3);

        idle_inputs();

        // Reset state, checked while rst is held with a request pending.
        m0_val = 1'b1; m0_addr = 32'h200;
        #3;
        chk("rst_mem_val", {31'd0, mem_val}, 32'd0);
        chk("rst_m0_wait", {31'd0, m0_wait}, 32'd1);
        chk("rst_m1_wait", {31'd0, m1_wait}, 32'd1);
        chk("rst_cnt0", cnt0, 32'd0);
        idle_inputs();
        pulse_reset();

        // Table-driven vectors, one per cycle.
        for (int i = 0; i < 7; i++) begin
            m0_val = tbl[i].v0; m0_type = tbl[i].t0; m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0;
            m1_val = tbl[i].v1; m1_type = tbl[i].t1; m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1;
            mw = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_mem_val", i), {31'd0, mem_val},  {31'd0, tbl[i].e_val});
            chk($sformatf("v%0d_mem_type", i), {31'd0, mem_type}, {31'd0, tbl[i].e_type});
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_m0_wait", i), {31'd0, m0_wait},  {31'd0, tbl[i].e_w0});
            chk($sformatf("v%0d_m1_wait", i), {31'd0, m1_wait},  {31'd0, tbl[i].e_w1});
            chk($sformatf("v%0d_m0_rdata", i), m0_rdata, tbl[i].e_rd0);
            chk($sformatf("v%0d_m1_rdata", i), m1_rdata, tbl[i].e_rd1);
            tick();
            chk($sformatf("v%0d_cnt0", i), cnt0, tbl[i].e_c0);
            chk($sformatf("v%0d_cnt1", i), cnt1, tbl[i].e_c1);
        end

        // Memory stalls: two wait cycles in IDLE, two in HOLD, done in cycle 6.
        idle_inputs();
        pulse_reset();
        m0_val = 1'b1; m0_addr = 32'h200;
        m1_val = 1'b1; m1_addr = 32'h1000;
        wpat = 6'b100100; // bit k = ~mem_wait in cycle k+1
        for (int c = 0; c < 6; c++) begin
            mw = ~wpat[c];
            @(negedge clk);
            chk($sformatf("stall_c%0d_addr", c + 1), mem_addr, (c < 3) ? 32'h200 : 32'h1000);
            chk($sformatf("stall_c%0d_m0_wait", c + 1), {31'd0, m0_wait}, (c == 5) ? 32'd0 : 32'd1);
            chk($sformatf("stall_c%0d_m1_wait", c + 1), {31'd0, m1_wait}, (c == 5) ? 32'd0 : 32'd1);
            if (c == 5) begin
                chk("stall_m0_rdata", m0_rdata, 32'h0050_0093);
                chk("stall_m1_rdata", m1_rdata, 32'hCAFE_0001);
            end
            tick();
            chk($sformatf("stall_c%0d_cnt0", c + 1), cnt0, (c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("stall_c%0d_cnt1", c + 1), cnt1, (c == 5) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset while in HOLD, then re-issue.
        idle_inputs();
        m0_val = 1'b1; m0_addr = 32'h200;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("hrst_mem_val", {31'd0, mem_val}, 32'd0);
        chk("hrst_m0_wait", {31'd0, m0_wait}, 32'd1);
        chk("hrst_m1_wait", {31'd0, m1_wait}, 32'd1);
        chk("hrst_m0_rdata", m0_rdata, 32'd0);
        chk("hrst_cnt0", cnt0, 32'd0);
        chk("hrst_cnt1", cnt1, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reiss_c1_mem_val", {31'd0, mem_val}, 32'd1);
        chk("reiss_c1_addr", mem_addr, 32'h200);
        chk("reiss_c1_m0_wait", {31'd0, m0_wait}, 32'd1);
        tick();
        @(negedge clk);
        chk("reiss_c2_m0_wait", {31'd0, m0_wait}, 32'd0);
        chk("reiss_c2_m0_rdata", m0_rdata, 32'h0050_0093);
        tick();
        chk("reiss_cnt0", cnt0, 32'd1);

        // Counter wrap on the 4-bit copy: 17 requester 1 completions.
        idle_inputs();
        pulse_reset();
        m1_val = 1'b1; m1_addr = 32'h1000;
        for (int k = 0; k < 17; k++) tick();
        chk("wrap_cnt1_w32", cnt1, 32'd17);
        chk("wrap_cnt1_w4", {28'd0, d4_cnt1}, 32'd1);
        chk("wrap_cnt0_w4", {28'd0, d4_cnt0}, 32'd0);
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
